// File: rtl/entry_alloc_pkg.sv
// rtl/entry_alloc_pkg.sv - shared types and width helpers for the entry allocator
package entry_alloc_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } alloc_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    int idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                winner   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/entry_allocator.sv
// rtl/entry_allocator.sv - free-bitmap entry allocator with RR arbitration and drain
// Optional stall statistics are built when ENTRY_ALLOC_STATS_EN is defined.
module entry_allocator
    import entry_alloc_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_REQ     = 4,
    localparam int IDX_W      = idx_w(NUM_ENTRIES),
    localparam int CNT_W      = cnt_w(NUM_ENTRIES),
    localparam int PTR_W      = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] alloc_req,
    output logic [NUM_REQ-1:0] alloc_gnt,
    output logic [IDX_W-1:0]   alloc_index,
    input  logic               free_valid,
    input  logic [IDX_W-1:0]   free_index,
    output logic               free_err,
    output logic [CNT_W-1:0]   free_count,
    output logic               full,
    output logic               empty,
    input  logic               drain_req,
    output logic               drain_done
`ifdef ENTRY_ALLOC_STATS_EN
   ,output logic [15:0]        alloc_stall_cnt
`endif
);

    alloc_state_e           state, state_next;
    logic [NUM_ENTRIES-1:0] bitmap;
    logic [NUM_ENTRIES-1:0] alloc_mask, free_mask;
    logic [PTR_W-1:0]       rr_ptr, ptr_next;
    logic [NUM_REQ-1:0]     eligible, arb_gnt;
    logic [PTR_W-1:0]       arb_winner;
    logic                   arb_any;
    logic [IDX_W-1:0]       high_idx;
    logic                   free_in_range, free_bit, free_ok, free_bad;
    logic                   do_alloc, drain_done_next;
    logic [CNT_W-1:0]       count_next;

    // A requester granted last cycle is masked so it can drop its request.
    assign eligible = alloc_req & ~alloc_gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (eligible),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .winner (arb_winner),
        .any    (arb_any)
    );

    always_comb begin
        high_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (bitmap[i]) high_idx = IDX_W'(i);
        end
    end

    always_comb begin
        free_in_range = int'(free_index) < NUM_ENTRIES;
        free_bit      = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_index == IDX_W'(i)) free_bit = bitmap[i];
        end
        free_ok  = free_valid && free_in_range && !free_bit;
        free_bad = free_valid && !free_ok;
    end

    // Drain request blocks the grant in the same cycle it is sampled.
    assign do_alloc = (state == RUN) && !drain_req && arb_any && (free_count != '0);

    // Allocation reads the pre-free bitmap, so the two masks never overlap.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            alloc_mask[i] = do_alloc && (high_idx == IDX_W'(i));
            free_mask[i]  = free_ok && (free_index == IDX_W'(i));
        end
    end

    assign count_next = free_count - CNT_W'(do_alloc) + CNT_W'(free_ok);
    assign ptr_next   = (arb_winner == PTR_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;

    always_comb begin
        state_next      = state;
        drain_done_next = 1'b0;
        case (state)
            RUN: begin
                if (drain_req) begin
                    if (count_next == CNT_W'(NUM_ENTRIES)) drain_done_next = 1'b1;
                    else                                   state_next      = DRAIN;
                end
            end
            DRAIN: begin
                if (count_next == CNT_W'(NUM_ENTRIES)) begin
                    state_next      = RUN;
                    drain_done_next = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            bitmap      <= '1;
            free_count  <= CNT_W'(NUM_ENTRIES);
            alloc_gnt   <= '0;
            alloc_index <= '0;
            rr_ptr      <= '0;
            free_err    <= 1'b0;
            drain_done  <= 1'b0;
        end else begin
            state      <= state_next;
            bitmap     <= (bitmap & ~alloc_mask) | free_mask;
            free_count <= count_next;
            alloc_gnt  <= do_alloc ? arb_gnt : '0;
            free_err   <= free_bad;
            drain_done <= drain_done_next;
            if (do_alloc) begin
                alloc_index <= high_idx;
                rr_ptr      <= ptr_next;
            end
        end
    end

    assign full  = (free_count == '0);
    assign empty = (free_count == CNT_W'(NUM_ENTRIES));

`ifdef ENTRY_ALLOC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_stall_cnt <= '0;
        end else if ((state == RUN) && (|eligible) && full && (alloc_stall_cnt != 16'hFFFF)) begin
            alloc_stall_cnt <= alloc_stall_cnt + 16'd1;
        end
    end
`else
    // No stall statistics in this build.
`endif

endmodule
